register_file_param: RTL

Parametrised integer register file for the single-cycle/pipelined RV32I core, replacing the fixed 32×32 file. It provides two registered read ports, two write ports with a defined collision priority, and an optional same-cycle write-to-read bypass. Register 0 is hardwired to zero. A configurable watch comparator drives the `result_out` self-check flag used by the test programs. It sits between the decode stage (addresses) and the writeback stage (write data/enables).

---
 rtl/register_file_param.sv | 62 ++++++
 1 files changed

// File: rtl/register_file_param.sv
// Parametrised integer register file: two registered read ports, two write
// ports (port 4 wins on an address collision) and an optional write-to-read bypass.
module register_file_param #(
  parameter int               XLEN      = 32,
  parameter int               NREGS     = 32,
  parameter int               AW        = $clog2(NREGS),
  parameter bit               BYPASS    = 1'b1,
  parameter int               WATCH_REG = 10,
  parameter logic [XLEN-1:0]  WATCH_VAL = 13
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  input  logic [AW-1:0]   A3,
  input  logic [XLEN-1:0] WD3,
  input  logic            WE3,
  input  logic [AW-1:0]   A4,
  input  logic [XLEN-1:0] WD4,
  input  logic            WE4,
  output logic            result_out
);

  localparam logic [AW-1:0] WATCH_IDX = AW'(WATCH_REG);

  logic [XLEN-1:0] regs [NREGS];
  logic [XLEN-1:0] nxt  [NREGS];
  logic            wr3;
  logic            wr4;

  // Writes to x0 are discarded, so x0 never leaves its reset value of zero.
  assign wr3 = WE3 && (A3 != '0);
  assign wr4 = WE4 && (A4 != '0);

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      // NOTE: every entry gets its hold value first, so no path leaves nxt unassigned (no latch).
      nxt[i] = regs[i];
      if (wr3 && (A3 == AW'(i))) nxt[i] = WD3;
      if (wr4 && (A4 == AW'(i))) nxt[i] = WD4;
    end
  end

  // NOTE: the storage array is reset as well, because software relies on all registers reading zero after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      RD1        <= '0;
      RD2        <= '0;
      result_out <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every read below sees the pre-edge array contents.
      for (int i = 1; i < NREGS; i++) regs[i] <= nxt[i];
      RD1        <= BYPASS ? nxt[A1] : regs[A1];
      RD2        <= BYPASS ? nxt[A2] : regs[A2];
      result_out <= (nxt[WATCH_IDX] == WATCH_VAL);
    end
  end

endmodule
